// File: rtl/button_debounce.sv
// button_debounce
//   Conditions a raw active-low push-button pin: two-flop synchroniser,
//   symmetric press/release debounce over DB_CYCLES clocks, clean level in
//   both polarities, and one-cycle press / release / long-press strobes.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   button         raw asynchronous pin, 0 = pressed
//   btn_level      debounced state, 1 = pressed
//   button_clean_n ~btn_level, for active-low downstream button inputs
//   press_pulse    one-cycle strobe on each debounced press
//   release_pulse  one-cycle strobe on each debounced release
//   long_pulse     one-cycle strobe once a press has been held LP_CYCLES
//
// DB_CYCLES must be >= 2 and LP_CYCLES must exceed DB_CYCLES.
module button_debounce #(
  parameter int OSC_F         = 24_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_level,
  output logic button_clean_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_CYCLES = OSC_F / 1000 * DEBOUNCE_MS;
  localparam int LP_CYCLES = OSC_F / 1000 * LONG_PRESS_MS;
  localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LP_W      = (LP_CYCLES > 1) ? $clog2(LP_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_PRE  = LP_W'(LP_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic            sync1, sync2;
  state_t          state, state_nxt;
  logic [DB_W-1:0] db_ctr, db_nxt;
  logic [LP_W-1:0] lp_ctr;
  logic            long_done;
  logic            press_evt, release_evt, long_evt, lp_run;

  // State register, synchroniser, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      state         <= IDLE;
      db_ctr        <= '0;
      lp_ctr        <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync1         <= button;
      sync2         <= sync1;
      state         <= state_nxt;
      db_ctr        <= db_nxt;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      long_pulse    <= long_evt;

      if (press_evt)
        btn_level <= 1'b1;
      else if (release_evt)
        btn_level <= 1'b0;

      // Counter restarts on every debounced edge and saturates at LP_LAST;
      // it keeps running through release bounces.
      if (press_evt || release_evt)
        lp_ctr <= '0;
      else if (lp_run && (lp_ctr != LP_LAST))
        lp_ctr <= lp_ctr + LP_W'(1);

      if (press_evt)
        long_done <= 1'b0;
      else if (long_evt)
        long_done <= 1'b1;
    end
  end

  // Next-state and debounce counter
  always_comb begin
    state_nxt   = state;
    db_nxt      = '0;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) begin
          state_nxt = PRESS_WAIT;
          db_nxt    = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        // A bounce takes precedence over a completing count.
        if (sync2) begin
          state_nxt = IDLE;
        end else if (db_ctr == DB_LAST) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          db_nxt = db_ctr + DB_W'(1);
        end
      end
      PRESSED: begin
        if (sync2) begin
          state_nxt = RELEASE_WAIT;
          db_nxt    = DB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!sync2) begin
          state_nxt = PRESSED;
        end else if (db_ctr == DB_LAST) begin
          state_nxt   = IDLE;
          release_evt = 1'b1;
        end else begin
          db_nxt = db_ctr + DB_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / event decode. long_pulse is raised on the edge where lp_ctr
  // steps to LP_LAST, i.e. LP_CYCLES-1 clocks after press_pulse; a release
  // completing on that same edge wins and suppresses it.
  always_comb begin
    lp_run         = (state == PRESSED) || (state == RELEASE_WAIT);
    long_evt       = lp_run && !release_evt && !long_done && (lp_ctr == LP_PRE);
    button_clean_n = ~btn_level;
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Directed stimulus for button_debounce with OSC_F=1000, DEBOUNCE_MS=4,
//   LONG_PRESS_MS=20 (DB_CYCLES=4, LP_CYCLES=20). Stimulus pushes expected
//   pulse events (kind, edge number) into a queue; a monitor sampling 1 time
//   unit after each rising edge pops and compares them and tracks the
//   expected debounced level.
module tb_button_debounce;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic button;
  logic btn_level, button_clean_n, press_pulse, release_pulse, long_pulse;

  ev_t  q[$];
  int   edge_n      = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_level   = 1'b0;

  button_debounce #(
    .OSC_F        (1000),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .btn_level     (btn_level),
    .button_clean_n(button_clean_n),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, edge_n, act, exp);
    end
  endfunction

  // Monitor / scoreboard
  initial begin : monitor
    logic rst_seen;
    logic exp_p, exp_r, exp_l;
    ev_t  e;
    forever begin
      @(posedge clk);
      edge_n++;
      rst_seen = rst_n;
      #1;
      exp_p = 1'b0;
      exp_r = 1'b0;
      exp_l = 1'b0;
      while (q.size() > 0 && q[0].at <= edge_n) begin
        e = q.pop_front();
        if (e.at < edge_n) begin
          vectors++;
          miscompares++;
          $display("FAIL stale_event kind %0d: due at edge %0d, now %0d", e.kind, e.at, edge_n);
        end else begin
          case (e.kind)
            K_PRESS:   exp_p = 1'b1;
            K_RELEASE: exp_r = 1'b1;
            default:   exp_l = 1'b1;
          endcase
        end
      end
      if (!rst_seen)  exp_level = 1'b0;
      else if (exp_p) exp_level = 1'b1;
      else if (exp_r) exp_level = 1'b0;
      chk("press_pulse",    press_pulse,    exp_p);
      chk("release_pulse",  release_pulse,  exp_r);
      chk("long_pulse",     long_pulse,     exp_l);
      chk("btn_level",      btn_level,      exp_level);
      chk("button_clean_n", button_clean_n, ~exp_level);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: stimulus did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  // Stimulus
  initial begin : stim
    int t;
    rst_n  = 1'b0;
    button = 1'b1;
    hold(3);
    rst_n = 1'b1;

    // Idle after reset: nothing happens
    hold(50);

    // Clean press, then clean release
    button = 1'b0;
    t = edge_n + 1;
    push(K_PRESS, t + 5);
    hold(10);
    button = 1'b1;
    t = edge_n + 1;
    push(K_RELEASE, t + 5);
    hold(20);

    // Bounce reject: low 3, high 1, low 3, high
    button = 1'b0; hold(3);
    button = 1'b1; hold(1);
    button = 1'b0; hold(3);
    button = 1'b1; hold(5);
    // Then a valid 6-cycle press
    button = 1'b0;
    t = edge_n + 1;
    push(K_PRESS,   t + 5);
    push(K_RELEASE, t + 6 + 5);
    hold(6);
    button = 1'b1;
    hold(20);

    // Long press: held 40 cycles
    button = 1'b0;
    t = edge_n + 1;
    push(K_PRESS, t + 5);
    push(K_LONG,  t + 5 + 19);
    hold(40);
    button = 1'b1;
    t = edge_n + 1;
    push(K_RELEASE, t + 5);
    hold(20);

    // Short press, release with a one-cycle low glitch at release+2
    button = 1'b0;
    t = edge_n + 1;
    push(K_PRESS, t + 5);
    hold(10);
    button = 1'b1;
    t = edge_n + 1;
    push(K_RELEASE, t + 8);
    hold(2);
    button = 1'b0; hold(1);
    button = 1'b1; hold(20);

    // Reset while PRESSED, button kept low
    button = 1'b0;
    t = edge_n + 1;
    push(K_PRESS, t + 5);
    hold(10);
    rst_n = 1'b0;
    hold(1);
    rst_n = 1'b1;
    t = edge_n + 1;
    push(K_PRESS, t + 5);
    hold(10);
    button = 1'b1;
    t = edge_n + 1;
    push(K_RELEASE, t + 5);
    hold(20);

    hold(5);
    while (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_event kind %0d: due at edge %0d", q[0].kind, q[0].at);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
